// File: rtl/quadenc_ext_if.sv
// Signal bundle between a quadrature decoder (slave) and its host (master).
// The index channel signals exist only when QUADENC_INDEX_EN is defined.
interface quadenc_ext_if #(
  parameter int CNT_W = 32
);
  logic             quadA;
  logic             quadB;
  logic [1:0]       mode;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             cap;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;
  logic [CNT_W-1:0] cap_count;
  logic             cap_valid;
`ifdef QUADENC_INDEX_EN
  logic             quadZ;
  logic             idx_clr_en;
  logic [CNT_W-1:0] idx_count;
  logic             idx_seen;

  modport master (
    output quadA, quadB, mode, load, load_val, cap, err_clr, quadZ, idx_clr_en,
    input  count, dir, step, err, cap_count, cap_valid, idx_count, idx_seen
  );
  modport slave (
    input  quadA, quadB, mode, load, load_val, cap, err_clr, quadZ, idx_clr_en,
    output count, dir, step, err, cap_count, cap_valid, idx_count, idx_seen
  );
`else
  modport master (
    output quadA, quadB, mode, load, load_val, cap, err_clr,
    input  count, dir, step, err, cap_count, cap_valid
  );
  modport slave (
    input  quadA, quadB, mode, load, load_val, cap, err_clr,
    output count, dir, step, err, cap_count, cap_valid
  );
`endif
endinterface

// File: rtl/quadenc_ext.sv
// Quadrature decoder: per-pin synchroniser and glitch filter, x4/x2/x1 step
// decode into a wrapping signed counter, sticky illegal-transition flag,
// preload and snapshot capture. An arming window after reset lets the
// filtered levels settle before any step is decoded.
// Optional index channel Z: define QUADENC_INDEX_EN.
module quadenc_ext #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input logic          clk,
  input logic          rst_n,
  quadenc_ext_if.slave bus
);

`ifdef QUADENC_INDEX_EN
  localparam int NCH  = 3;
  localparam int CH_Z = 2;
`else
  localparam int NCH  = 2;
`endif
  localparam int CH_A = 0;
  localparam int CH_B = 1;

  localparam int            FW        = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam int            ARM_LEN   = SYNC_STAGES + FILT_LEN + 1;
  localparam int            AW        = $clog2(ARM_LEN + 1);
  localparam logic [AW-1:0] ARM_DONE  = AW'(ARM_LEN);

  typedef enum logic [1:0] {
    MODE_X4  = 2'd0,
    MODE_X2  = 2'd1,
    MODE_X1  = 2'd2,
    MODE_X4B = 2'd3
  } mode_e;

  logic [NCH-1:0]         pin;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]         filt_q, filt_d;
  logic [FW-1:0]          fcnt_q [NCH];
  logic [FW-1:0]          fcnt_d [NCH];
  logic [NCH-1:0]         prev_q;
  logic [AW-1:0]          arm_q, arm_d;
  logic                   armed;

  logic [CNT_W-1:0]       count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cap_count_q, cap_count_d;
  logic                   cap_valid_q, cap_valid_d;

  logic cur_a, cur_b, chg_a, chg_b, counts, up, illegal, step_ev;

`ifdef QUADENC_INDEX_EN
  logic [CNT_W-1:0] idx_count_q, idx_count_d;
  logic             idx_seen_q, idx_seen_d;
  logic             z_rise;

  assign pin = {bus.quadZ, bus.quadB, bus.quadA};
`else
  assign pin = {bus.quadB, bus.quadA};
`endif

  assign armed = (arm_q == ARM_DONE);

  // Bring each asynchronous pin into the clock domain through its own chain.
  // NOTE: flops use <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) sync_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], pin[c]};
    end
  end

  // Glitch filter: adopt the synchronised level after FILT_LEN consecutive disagreeing cycles.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    filt_d = filt_q;
    for (int c = 0; c < NCH; c++) begin
      fcnt_d[c] = '0;
      if (sync_q[c][SYNC_STAGES-1] != filt_q[c]) begin
        if (fcnt_q[c] == FILT_LAST) filt_d[c] = sync_q[c][SYNC_STAGES-1];
        else                        fcnt_d[c] = fcnt_q[c] + FW'(1);
      end
    end
  end

  // Classify the filtered A/B change against the previous state for the active mode.
  always_comb begin
    cur_a = filt_q[CH_A];
    cur_b = filt_q[CH_B];
    chg_a = cur_a ^ prev_q[CH_A];
    chg_b = cur_b ^ prev_q[CH_B];
    up    = cur_a ^ prev_q[CH_B];
    case (mode_e'(bus.mode))
      MODE_X2: counts = chg_a;
      MODE_X1: counts = chg_a & cur_a;
      default: counts = 1'b1;
    endcase
    illegal = armed & chg_a & chg_b;
    step_ev = armed & (chg_a ^ chg_b) & counts;
  end

  // Counter, flags and capture; priority rises from step to index clear to load.
  always_comb begin
    arm_d       = armed ? arm_q : arm_q + AW'(1);
    count_d     = count_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = err_q;
    cap_count_d = cap_count_q;
    cap_valid_d = cap_valid_q;
    if (step_ev) begin
      count_d = up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      dir_d   = up;
      step_d  = 1'b1;
    end
`ifdef QUADENC_INDEX_EN
    z_rise      = armed & filt_q[CH_Z] & ~prev_q[CH_Z];
    idx_count_d = idx_count_q;
    idx_seen_d  = idx_seen_q;
    if (z_rise) begin
      idx_count_d = count_q;
      idx_seen_d  = 1'b1;
      if (bus.idx_clr_en) begin
        count_d = '0;
        dir_d   = dir_q;
        step_d  = 1'b0;
      end
    end
`endif
    if (bus.load) begin
      count_d = bus.load_val;
      dir_d   = dir_q;
      step_d  = 1'b0;
    end
    if (bus.err_clr) err_d = 1'b0;
    if (illegal)     err_d = 1'b1;
    if (bus.cap) begin
      cap_count_d = count_q;
      cap_valid_d = 1'b1;
    end
  end

  // State registers; prev simply follows the filtered levels every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= '0;
      for (int c = 0; c < NCH; c++) fcnt_q[c] <= '0;
      prev_q      <= '0;
      arm_q       <= '0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      cap_count_q <= '0;
      cap_valid_q <= 1'b0;
`ifdef QUADENC_INDEX_EN
      idx_count_q <= '0;
      idx_seen_q  <= 1'b0;
`endif
    end else begin
      filt_q      <= filt_d;
      for (int c = 0; c < NCH; c++) fcnt_q[c] <= fcnt_d[c];
      prev_q      <= filt_q;
      arm_q       <= arm_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      cap_count_q <= cap_count_d;
      cap_valid_q <= cap_valid_d;
`ifdef QUADENC_INDEX_EN
      idx_count_q <= idx_count_d;
      idx_seen_q  <= idx_seen_d;
`endif
    end
  end

  assign bus.count     = count_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.cap_count = cap_count_q;
  assign bus.cap_valid = cap_valid_q;
`ifdef QUADENC_INDEX_EN
  assign bus.idx_count = idx_count_q;
  assign bus.idx_seen  = idx_seen_q;
`endif

endmodule

// File: tb/tb_quadenc_ext.sv
// Self-checking bench for quadenc_ext: directed scenarios with literal
// expectations, then randomized pin/strobe activity, all compared every
// cycle against a history-based reference model.
module tb_quadenc_ext;
  localparam int CNT_W   = 32;
  localparam int S       = 2;
  localparam int F       = 4;
  localparam int ARM_LEN = S + F + 1;
  localparam int MAXE    = 16384;

  logic clk;
  logic rst_n;
  quadenc_ext_if #(.CNT_W(CNT_W)) bus ();

  quadenc_ext #(.CNT_W(CNT_W), .SYNC_STAGES(S), .FILT_LEN(F)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;
  int dut_steps = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Histories indexed by clock edge since reset release (index 0 = reset state).
  bit raw_h [3][MAXE];
  bit sy_h  [3][MAXE];
  bit fl_h  [3][MAXE];
  int last_adopt [3];
  int e;
  int m_steps;
  logic [CNT_W-1:0] m_count, m_cap_count, m_idx_count;
  bit m_dir, m_step, m_err, m_cap_valid, m_idx_seen;

  function automatic bit fl_at(int c, int k);
    if (k < 0) return 1'b0;
    return fl_h[c][k];
  endfunction

  // Position along the forward Gray cycle 00 -> 10 -> 11 -> 01 ({A,B}).
  function automatic int gray_pos(logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    e = 0;
    for (int c = 0; c < 3; c++) begin
      raw_h[c][0] = 1'b0; sy_h[c][0] = 1'b0; fl_h[c][0] = 1'b0; last_adopt[c] = 0;
    end
    m_count = '0; m_cap_count = '0; m_idx_count = '0;
    m_dir = 0; m_step = 0; m_err = 0; m_cap_valid = 0; m_idx_seen = 0;
  endtask

  task automatic model_edge();
    bit pins [3];
    bit adopt, armed, counted, illegal, up, zr;
    logic [1:0] cur, prv;
    int d;
    logic [CNT_W-1:0] nxt_count;
    bit nxt_dir, nxt_step;
    pins[0] = bus.quadA;
    pins[1] = bus.quadB;
`ifdef QUADENC_INDEX_EN
    pins[2] = bus.quadZ;
`else
    pins[2] = 1'b0;
`endif
    e++;
    if (e >= MAXE) begin
      n_bad++;
      $display("FAIL model_depth: got %0d edges, limit %0d", e, MAXE);
      $fatal(1, "model history exhausted");
    end
    // Decode uses the filtered levels as they stood before this edge.
    armed = (e > ARM_LEN);
    cur = {fl_at(0, e - 1), fl_at(1, e - 1)};
    prv = {fl_at(0, e - 2), fl_at(1, e - 2)};
    d = (gray_pos(cur) - gray_pos(prv) + 4) % 4;
    up = (d == 1);
    illegal = armed && (d == 2);
    counted = 0;
    if (armed && (d == 1 || d == 3)) begin
      case (bus.mode)
        2'd1:    counted = (cur[1] != prv[1]);
        2'd2:    counted = cur[1] && !prv[1];
        default: counted = 1'b1;
      endcase
    end
    nxt_count = m_count; nxt_dir = m_dir; nxt_step = 0;
    if (counted) begin
      nxt_count = up ? m_count + 1 : m_count - 1;
      nxt_dir = up; nxt_step = 1;
    end
    zr = armed && fl_at(2, e - 1) && !fl_at(2, e - 2);
`ifdef QUADENC_INDEX_EN
    if (zr) begin
      m_idx_count = m_count;
      m_idx_seen = 1;
      if (bus.idx_clr_en) begin nxt_count = '0; nxt_dir = m_dir; nxt_step = 0; end
    end
`endif
    if (bus.load) begin nxt_count = bus.load_val; nxt_dir = m_dir; nxt_step = 0; end
    if (bus.cap) begin m_cap_count = m_count; m_cap_valid = 1; end
    if (bus.err_clr) m_err = 0;
    if (illegal) m_err = 1;
    m_count = nxt_count; m_dir = nxt_dir; m_step = nxt_step;
    if (nxt_step) m_steps++;
    // Pin histories: sync is the pin delayed by the chain; filt flips once the
    // last F sync samples all disagreed with it and F edges passed since the last flip.
    for (int c = 0; c < 3; c++) begin
      raw_h[c][e] = pins[c];
      sy_h[c][e] = (e - S + 1 >= 1) ? raw_h[c][e - S + 1] : 1'b0;
      adopt = (e - last_adopt[c] >= F);
      if (adopt)
        for (int j = e - F; j < e; j++)
          if (sy_h[c][j] == fl_h[c][e - 1]) adopt = 0;
      fl_h[c][e] = adopt ? !fl_h[c][e - 1] : fl_h[c][e - 1];
      if (adopt) last_adopt[c] = e;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Per-cycle comparison, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("count", bus.count, m_count);
      check("dir", bus.dir, m_dir);
      check("step", bus.step, m_step);
      check("err", bus.err, m_err);
      check("cap_count", bus.cap_count, m_cap_count);
      check("cap_valid", bus.cap_valid, m_cap_valid);
`ifdef QUADENC_INDEX_EN
      check("idx_count", bus.idx_count, m_idx_count);
      check("idx_seen", bus.idx_seen, m_idx_seen);
`endif
      if (bus.step === 1'b1) dut_steps++;
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] seq_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int pos;

  task automatic pin_lit(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                         input logic [63:0] lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input bit fwd, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
      {bus.quadA, bus.quadB} = seq_ab[pos];
      idle(gap - 1);
    end
  endtask

  task automatic pulse_load(input logic [CNT_W-1:0] v);
    @(negedge clk);
    bus.load_val = v; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] all_ones;
    int s0;
    all_ones = '1;
    rst_n = 1'b0;
    bus.quadA = 1'b1; bus.quadB = 1'b1; bus.mode = 2'd0;
    bus.load = 1'b0; bus.load_val = '0; bus.cap = 1'b0; bus.err_clr = 1'b0;
`ifdef QUADENC_INDEX_EN
    bus.quadZ = 1'b0; bus.idx_clr_en = 1'b0;
`endif
    pos = 2;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    pin_lit("arm_count", bus.count, m_count, 0);
    pin_lit("arm_err", bus.err, m_err, 0);
    pin_lit("arm_steps", dut_steps, m_steps, 0);

    // x4 forward then reverse
    move(1, 16, 20); idle(20);
    pin_lit("x4_fwd_count", bus.count, m_count, 16);
    pin_lit("x4_fwd_dir", bus.dir, m_dir, 1);
    pin_lit("x4_fwd_steps", dut_steps, m_steps, 16);
    move(0, 16, 20); idle(20);
    pin_lit("x4_rev_count", bus.count, m_count, 0);
    pin_lit("x4_rev_dir", bus.dir, m_dir, 0);

    // x2 then x1
    bus.mode = 2'd1;
    move(1, 16, 20); idle(20);
    pin_lit("x2_count", bus.count, m_count, 8);
    bus.mode = 2'd2;
    move(1, 16, 20); idle(20);
    pin_lit("x1_count", bus.count, m_count, 12);

    // 3-cycle glitch on A is filtered out
    @(negedge clk); bus.quadA = ~bus.quadA;
    idle(3);        bus.quadA = ~bus.quadA;
    idle(20);
    pin_lit("glitch_count", bus.count, m_count, 12);
    // both channels toggle together
    @(negedge clk); {bus.quadA, bus.quadB} = ~{bus.quadA, bus.quadB};
    pos = gray_pos({bus.quadA, bus.quadB});
    idle(20);
    pin_lit("illegal_count", bus.count, m_count, 12);
    pin_lit("illegal_err", bus.err, m_err, 1);
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    idle(2);
    pin_lit("err_clr", bus.err, m_err, 0);

    // preload all-ones then wrap forward
    bus.mode = 2'd0;
    pulse_load(all_ones); idle(2);
    pin_lit("load_ones", bus.count, m_count, all_ones);
    move(1, 1, 20);
    pin_lit("wrap_count", bus.count, m_count, 0);
    // load on the same edge as a step
    s0 = dut_steps;
    @(negedge clk);
    pos = (pos + 1) % 4; {bus.quadA, bus.quadB} = seq_ab[pos];
    idle(S + F);
    bus.load_val = 32'h1234; bus.load = 1'b1;
    @(negedge clk); bus.load = 1'b0;
    idle(20);
    pin_lit("load_vs_step_count", bus.count, m_count, 32'h1234);
    check("load_vs_step_pulse", dut_steps - s0, 0);

    // capture on the same edge as a step from 5
    pulse_load(5); idle(2);
    @(negedge clk);
    pos = (pos + 1) % 4; {bus.quadA, bus.quadB} = seq_ab[pos];
    idle(S + F);
    bus.cap = 1'b1;
    @(negedge clk); bus.cap = 1'b0;
    idle(20);
    pin_lit("cap_count", bus.cap_count, m_cap_count, 5);
    pin_lit("cap_then_count", bus.count, m_count, 6);
    pin_lit("cap_valid", bus.cap_valid, m_cap_valid, 1);

`ifdef QUADENC_INDEX_EN
    pulse_load(37); idle(2);
    bus.idx_clr_en = 1'b1;
    @(negedge clk); bus.quadZ = 1'b1;
    idle(10);       bus.quadZ = 1'b0;
    idle(20);
    bus.idx_clr_en = 1'b0;
    pin_lit("idx_count", bus.idx_count, m_idx_count, 37);
    pin_lit("idx_clear_count", bus.count, m_count, 0);
    pin_lit("idx_seen", bus.idx_seen, m_idx_seen, 1);
`endif

    // randomized pins, modes and strobes, with one mid-run reset
    for (int blk = 0; blk < 400; blk++) begin
      int r, hold;
      if (blk == 200) begin
        @(negedge clk); #2 rst_n = 1'b0;
        bus.load = 1'b0; bus.cap = 1'b0; bus.err_clr = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(ARM_LEN + 2);
      end
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if ($urandom_range(0, 1) == 1) bus.quadA = ~bus.quadA;
        else                           bus.quadB = ~bus.quadB;
      end else if (r < 76) begin
        {bus.quadA, bus.quadB} = ~{bus.quadA, bus.quadB};
      end
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
`ifdef QUADENC_INDEX_EN
      if ($urandom_range(0, 9) == 0) bus.quadZ = ~bus.quadZ;
      bus.idx_clr_en = ($urandom_range(0, 1) == 1);
`endif
      hold = $urandom_range(1, 14);
      for (int h = 0; h < hold; h++) begin
        bus.load     = ($urandom_range(0, 59) == 0);
        bus.load_val = $urandom;
        bus.cap      = ($urandom_range(0, 29) == 0);
        bus.err_clr  = ($urandom_range(0, 39) == 0);
        @(negedge clk);
      end
      bus.load = 1'b0; bus.cap = 1'b0; bus.err_clr = 1'b0;
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
